// File: rtl/obi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | obi_pkg -- shared types and constants for the 2:1 OBI arbiter             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package obi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } obi_state_e;

  localparam logic [31:0] c_timeout_rdata_default = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/obi_arb_2to1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | obi_arb_2to1 -- round-robin 2:1 OBI arbiter, one outstanding transaction, |
// | with a response timeout toward a non-pipelined downstream CDC. Rev 1.0    |
// +----------------------------------------------------------------------------+
module obi_arb_2to1
  import obi_pkg::*;
#(
  parameter int unsigned RVALID_TIMEOUT = 1023,
  parameter logic [31:0] TIMEOUT_RDATA  = c_timeout_rdata_default
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        p0_req_i,
  output logic        p0_gnt_o,
  input  logic [31:0] p0_addr_i,
  input  logic        p0_we_i,
  input  logic [3:0]  p0_be_i,
  input  logic [31:0] p0_wdata_i,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,

  input  logic        p1_req_i,
  output logic        p1_gnt_o,
  input  logic [31:0] p1_addr_i,
  input  logic        p1_we_i,
  input  logic [3:0]  p1_be_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,

  output logic        secondary_req_o,
  output logic [31:0] secondary_addr_o,
  output logic        secondary_we_o,
  output logic [3:0]  secondary_be_o,
  output logic [31:0] secondary_wdata_o,
  input  logic        secondary_gnt_i,
  input  logic        secondary_rvalid_i,
  input  logic [31:0] secondary_rdata_i,

  output logic        timeout_o
);

  // A zero timeout still needs a 1-bit counter so the declarations stay legal.
  localparam int unsigned c_cnt_w = (RVALID_TIMEOUT > 0) ? $clog2(RVALID_TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;
  localparam logic [c_cnt_w-1:0] c_cnt_term = c_cnt_w'(RVALID_TIMEOUT - 1);

  obi_state_e         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_served_q, last_served_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  logic        w_winner;
  logic        w_owner_req;
  logic        w_term;
  logic        w_req_sel;
  logic        w_gnt_sel;
  logic        w_rvalid_sel;
  logic [31:0] w_rdata_sel;
  logic        w_to_pulse;
  logic        w_live;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      cnt_q         <= cnt_d;
    end
  end

  // On a tie the primary not served last wins; a lone requester wins outright.
  assign w_winner    = (p0_req_i && p1_req_i) ? ~last_served_q : ~p0_req_i;
  assign w_owner_req = owner_q ? p1_req_i : p0_req_i;
  assign w_term      = (RVALID_TIMEOUT != 0) && (cnt_q == c_cnt_term);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    cnt_d         = cnt_q;
    w_req_sel     = 1'b0;
    w_gnt_sel     = 1'b0;
    w_rvalid_sel  = 1'b0;
    w_rdata_sel   = '0;
    w_to_pulse    = 1'b0;

    case (state_q)
      IDLE: begin
        if (p0_req_i || p1_req_i) begin
          owner_d = w_winner;
          state_d = REQ;
        end
      end

      REQ: begin
        w_req_sel = 1'b1;
        w_gnt_sel = secondary_gnt_i;
        if (secondary_gnt_i) begin
          state_d       = RESP;
          last_served_d = owner_q;
          cnt_d         = '0;
        end else if (!w_owner_req) begin
          state_d = IDLE;
        end
      end

      RESP: begin
        if (secondary_rvalid_i) begin
          w_rvalid_sel = 1'b1;
          w_rdata_sel  = secondary_rdata_i;
          state_d      = IDLE;
        end else if (w_term) begin
          w_rvalid_sel = 1'b1;
          w_rdata_sel  = TIMEOUT_RDATA;
          w_to_pulse   = 1'b1;
          state_d      = IDLE;
        end else if ((RVALID_TIMEOUT != 0) && (cnt_q != c_cnt_max)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, whatever the stale state.
  assign w_live = ~rst_i;

  assign secondary_req_o   = w_live & w_req_sel;
  assign secondary_addr_o  = secondary_req_o ? (owner_q ? p1_addr_i  : p0_addr_i)  : '0;
  assign secondary_we_o    = secondary_req_o & (owner_q ? p1_we_i : p0_we_i);
  assign secondary_be_o    = secondary_req_o ? (owner_q ? p1_be_i    : p0_be_i)    : '0;
  assign secondary_wdata_o = secondary_req_o ? (owner_q ? p1_wdata_i : p0_wdata_i) : '0;

  assign p0_gnt_o    = w_live & w_gnt_sel & ~owner_q;
  assign p1_gnt_o    = w_live & w_gnt_sel &  owner_q;
  assign p0_rvalid_o = w_live & w_rvalid_sel & ~owner_q;
  assign p1_rvalid_o = w_live & w_rvalid_sel &  owner_q;
  assign p0_rdata_o  = p0_rvalid_o ? w_rdata_sel : '0;
  assign p1_rdata_o  = p1_rvalid_o ? w_rdata_sel : '0;
  assign timeout_o   = w_live & w_to_pulse;

endmodule
`default_nettype wire

// File: tb/tb_obi_arb_2to1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_obi_arb_2to1 -- vector table, directed corner cases and random run      |
// | against a transaction-level model. Rev 1.0                                 |
// +----------------------------------------------------------------------------+
module tb_obi_arb_2to1;

  localparam int          TO   = 8;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic        clk, rst;
  logic        p0_req, p0_gnt_o, p0_we, p0_rvalid_o;
  logic [31:0] p0_addr, p0_wdata, p0_rdata_o;
  logic [3:0]  p0_be;
  logic        p1_req, p1_gnt_o, p1_we, p1_rvalid_o;
  logic [31:0] p1_addr, p1_wdata, p1_rdata_o;
  logic [3:0]  p1_be;
  logic        secondary_req_o, secondary_we_o, timeout_o;
  logic [31:0] secondary_addr_o, secondary_wdata_o;
  logic [3:0]  secondary_be_o;
  logic        sec_gnt, sec_rv;
  logic [31:0] sec_rd;

  obi_arb_2to1 #(.RVALID_TIMEOUT(TO), .TIMEOUT_RDATA(DEAD)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(p0_req), .p0_gnt_o(p0_gnt_o), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
    .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req), .p1_gnt_o(p1_gnt_o), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
    .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .secondary_req_o(secondary_req_o), .secondary_addr_o(secondary_addr_o),
    .secondary_we_o(secondary_we_o), .secondary_be_o(secondary_be_o),
    .secondary_wdata_o(secondary_wdata_o), .secondary_gnt_i(sec_gnt),
    .secondary_rvalid_i(sec_rv), .secondary_rdata_i(sec_rd), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, r0, r1, sg, rv;
    logic [31:0] rd;
    logic        g0, g1, v0, v1, sreq, to;
    logic [31:0] rd0, rd1, addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_, r0, r1, sg, rv, input logic [31:0] rd,
                              input logic g0, g1, v0, v1, sreq, to,
                              input logic [31:0] rd0, rd1, addr);
    vec_t v;
    v.rst = rst_; v.r0 = r0; v.r1 = r1; v.sg = sg; v.rv = rv; v.rd = rd;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.sreq = sreq; v.to = to;
    v.rd0 = rd0; v.rd1 = rd1; v.addr = addr;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Transaction view: who owns the port, whether the grant happened, and
  // how many cycles have elapsed since that grant.
  int m_owner   = -1;
  bit m_granted = 1'b0;
  int m_age     = 0;
  int m_last    = 1;

  function automatic logic [138:0] model_out();
    logic        g0, g1, v0, v1, sreq, to, we;
    logic [31:0] rd0, rd1, addr, wdata, rdata;
    logic [3:0]  be;
    {g0, g1, v0, v1, sreq, to, we} = '0;
    {rd0, rd1, addr, wdata, rdata} = '0;
    be = '0;
    if (!rst && m_owner >= 0) begin
      if (!m_granted) begin
        sreq  = 1'b1;
        addr  = (m_owner == 1) ? p1_addr  : p0_addr;
        we    = (m_owner == 1) ? p1_we    : p0_we;
        be    = (m_owner == 1) ? p1_be    : p0_be;
        wdata = (m_owner == 1) ? p1_wdata : p0_wdata;
        if (m_owner == 1) g1 = sec_gnt; else g0 = sec_gnt;
      end else begin
        to = !sec_rv && (m_age == TO);
        if (sec_rv || to) begin
          rdata = sec_rv ? sec_rd : DEAD;
          if (m_owner == 1) begin v1 = 1'b1; rd1 = rdata; end
          else              begin v0 = 1'b1; rd0 = rdata; end
        end
      end
    end
    return {g0, g1, v0, v1, sreq, to, rd0, rd1, addr, we, be, wdata};
  endfunction

  task automatic model_step();
    logic oreq;
    if (rst) begin
      m_owner = -1; m_granted = 1'b0; m_age = 0; m_last = 1;
    end else if (m_owner < 0) begin
      if (p0_req || p1_req) begin
        m_owner   = (p0_req && p1_req) ? 1 - m_last : (p0_req ? 0 : 1);
        m_granted = 1'b0;
      end
    end else if (!m_granted) begin
      oreq = (m_owner == 1) ? p1_req : p0_req;
      if (sec_gnt) begin
        m_granted = 1'b1; m_age = 1; m_last = m_owner;
      end else if (!oreq) begin
        m_owner = -1;
      end
    end else if (sec_rv || m_age == TO) begin
      m_owner = -1; m_granted = 1'b0;
    end else begin
      m_age++;
    end
  endtask

  function automatic logic [138:0] dut_out();
    return {p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, secondary_req_o, timeout_o,
            p0_rdata_o, p1_rdata_o, secondary_addr_o, secondary_we_o, secondary_be_o,
            secondary_wdata_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; p0_req = 1'b0; p1_req = 1'b0; sec_gnt = 1'b0; sec_rv = 1'b0; sec_rd = '0;
    p0_addr = 32'h10; p0_we = 1'b0; p0_be = 4'hF; p0_wdata = 32'h0;
    p1_addr = 32'h20; p1_we = 1'b1; p1_be = 4'h3; p1_wdata = 32'hAAAA_5555;

    //            rst r0 r1 sg rv rd            g0 g1 v0 v1 sq to rd0           rd1       addr
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0,            0,        32'h10));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0,            1, 0, 0, 0, 1, 0, 0,            0,        32'h10));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h12345678, 0, 0, 1, 0, 0, 0, 32'h12345678, 0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0,        0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0,        0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0,        0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,            1, 0, 0, 0, 1, 0, 0,            0,        32'h10));
    vecs.push_back(mk(0, 1, 1, 0, 1, 32'h11,       0, 0, 1, 0, 0, 0, 32'h11,       0,        0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0,        0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,            0, 1, 0, 0, 1, 0, 0,            0,        32'h20));
    vecs.push_back(mk(0, 1, 1, 0, 1, 32'h22,       0, 0, 0, 1, 0, 0, 0,            32'h22,   0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0,        0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,            1, 0, 0, 0, 1, 0, 0,            0,        32'h10));
    vecs.push_back(mk(0, 1, 1, 0, 1, 32'h33,       0, 0, 1, 0, 0, 0, 32'h33,       0,        0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0,        0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,            0, 1, 0, 0, 1, 0, 0,            0,        32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h44,       0, 0, 0, 1, 0, 0, 0,            32'h44,   0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h99,       0, 0, 0, 0, 0, 0, 0,            0,        0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; p0_req = vecs[i].r0; p1_req = vecs[i].r1;
      sec_gnt = vecs[i].sg; sec_rv = vecs[i].rv; sec_rd = vecs[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            160'({p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, secondary_req_o, timeout_o,
                  p0_rdata_o, p1_rdata_o, secondary_addr_o}),
            160'({vecs[i].g0, vecs[i].g1, vecs[i].v0, vecs[i].v1, vecs[i].sreq, vecs[i].to,
                  vecs[i].rd0, vecs[i].rd1, vecs[i].addr}));
      step();
    end
    rst = 1'b0; p0_req = 1'b0; p1_req = 1'b0; sec_gnt = 1'b0; sec_rv = 1'b0; sec_rd = '0;

    // Timeout on a p1 write, then a stray late response.
    rst = 1'b1; step(); rst = 1'b0;
    p1_req = 1'b1;
    @(negedge clk); check("to_idle", 160'({p1_gnt_o, secondary_req_o}), 160'(2'b00)); step();
    sec_gnt = 1'b1;
    @(negedge clk); check("to_gnt", 160'({p1_gnt_o, p0_gnt_o, secondary_we_o}), 160'(3'b101)); step();
    p1_req = 1'b0; sec_gnt = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      if (i < TO)
        check($sformatf("to_wait%0d", i), 160'({p1_rvalid_o, timeout_o}), 160'(2'b00));
      else
        check("to_fire", 160'({p1_rvalid_o, p0_rvalid_o, timeout_o, p1_rdata_o}),
              160'({3'b101, DEAD}));
      step();
    end
    sec_rv = 1'b1; sec_rd = 32'h5555;
    @(negedge clk); check("to_stray", 160'({p0_rvalid_o, p1_rvalid_o, timeout_o}), 160'(3'b000)); step();
    sec_rv = 1'b0;

    // Real response arriving on the terminal-count cycle wins.
    p0_req = 1'b1; step();
    sec_gnt = 1'b1;
    @(negedge clk); check("tc_gnt", 160'(p0_gnt_o), 160'(1'b1)); step();
    p0_req = 1'b0; sec_gnt = 1'b0;
    repeat (TO - 1) step();
    sec_rv = 1'b1; sec_rd = 32'hCAFE_F00D;
    @(negedge clk);
    check("tc_real", 160'({p0_rvalid_o, timeout_o, p0_rdata_o}), 160'({2'b10, 32'hCAFE_F00D}));
    step(); sec_rv = 1'b0;

    // Reset while waiting for a response drops it; p1 is then served promptly.
    p0_req = 1'b1; step();
    sec_gnt = 1'b1; step();
    p0_req = 1'b0; sec_gnt = 1'b0;
    rst = 1'b1; sec_rv = 1'b1; sec_rd = 32'h7777;
    @(negedge clk);
    check("rst_resp", 160'({p0_rvalid_o, p1_rvalid_o, secondary_req_o, timeout_o}), 160'(4'b0000));
    step();
    rst = 1'b0; p1_req = 1'b1;
    @(negedge clk);
    check("rst_after", 160'({p0_rvalid_o, p1_rvalid_o, p1_gnt_o, secondary_req_o}), 160'(4'b0000));
    step();
    sec_rv = 1'b0; sec_gnt = 1'b1;
    @(negedge clk);
    check("rst_p1_req", 160'({secondary_req_o, p1_gnt_o, p0_gnt_o, secondary_addr_o}),
          160'({3'b110, 32'h20}));
    step();
    p1_req = 1'b0; sec_gnt = 1'b0; sec_rv = 1'b1; sec_rd = 32'h88;
    @(negedge clk); check("rst_p1_resp", 160'({p1_rvalid_o, p1_rdata_o}), 160'({1'b1, 32'h88})); step();
    sec_rv = 1'b0;

    // p0 aborts before grant; the waiting p1 request follows.
    p0_req = 1'b1; step();
    p0_req = 1'b0; p1_req = 1'b1;
    @(negedge clk); check("abort_nogrant", 160'({p0_gnt_o, p1_gnt_o}), 160'(2'b00)); step();
    @(negedge clk); check("abort_idle", 160'({secondary_req_o, p0_gnt_o, p1_gnt_o}), 160'(3'b000)); step();
    sec_gnt = 1'b1;
    @(negedge clk);
    check("abort_p1", 160'({secondary_req_o, p1_gnt_o, secondary_addr_o}), 160'({2'b11, 32'h20}));
    step();
    p1_req = 1'b0; sec_gnt = 1'b0; sec_rv = 1'b1; sec_rd = 32'h1;
    step(); sec_rv = 1'b0;

    // Randomized run against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst      = (c == 0) || ($urandom_range(99) == 0);
      p0_req   = ($urandom_range(9) < 6);
      p1_req   = ($urandom_range(9) < 6);
      p0_addr  = $urandom; p1_addr = $urandom;
      p0_wdata = $urandom; p1_wdata = $urandom;
      p0_we    = 1'($urandom); p1_we = 1'($urandom);
      p0_be    = 4'($urandom); p1_be = 4'($urandom);
      sec_gnt  = ($urandom_range(9) < 4);
      sec_rv   = ($urandom_range(99) < 15);
      sec_rd   = $urandom;
      @(negedge clk);
      check($sformatf("rand%0d", c), 160'(dut_out()), 160'(model_out()));
      model_step();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
